bit_clmul_arbiter: RTL and testbench
====================================

# bit_clmul_arbiter

Shares one multi-cycle carry-less multiply unit (`bit_clmul`) between the two issue lanes of the core. It sequences each operation into the unit, holds operands stable, and returns the result to the lane that won arbitration. When both lanes request in the same cycle, round-robin arbitration picks the winner. A pipeline flush cancels the in-flight operation; the unit still runs to completion and its result is discarded.

## Interface
- `XLEN`, 32, operand/result width
- `clock`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `req0_valid`  in  1  lane 0 request, held until `req0_done`
- `req0_op`  in  3  lane 0 op: bit0 clmul, bit1 clmulh, bit2 clmulr
- `req0_rdata1`, `req0_rdata2`  in  XLEN  lane 0 operands
- `req1_valid`, `req1_op`, `req1_rdata1`, `req1_rdata2`  in  1/3/XLEN/XLEN  lane 1, same meaning as lane 0
- `flush`  in  1  cancel the in-flight operation and block new grants this cycle
- `req0_done`, `req1_done`  out  1  one-cycle pulse; `result` is valid for that lane
- `result`  out  XLEN  registered result
- `busy`  out  1  high in every state except IDLE
- `unit_enable`  out  1  one-cycle start pulse to the unit
- `unit_op`  out  3  one-hot op to the unit
- `unit_rdata1`, `unit_rdata2`  out  XLEN  latched operands, stable from ISSUE through WAIT/DRAIN
- `unit_result`  in  XLEN  unit result
- `unit_ready`  in  1  unit completion strobe

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- **IDLE**
  - A lane is eligible when `valid` = 1 and `op` ≠ 0.
  - If `flush` = 0 and at least one lane is eligible, grant one lane, latch its op and operands, and go to ISSUE.
  - `op` = 0 is never granted.
  - A multi-hot op is normalized by priority: clmul > clmulh > clmulr.
- **Arbitration**
  - Single eligible lane: that lane wins.
  - Both eligible: the lane ≠ `last` wins.
  - `last` updates to the granted lane on every grant. Reset value is 1, so lane 0 wins the first tie.
- **ISSUE**
  - `unit_enable` = 1 for exactly this cycle.
  - Next state is WAIT, or DRAIN if `flush` = 1.
- **WAIT**
  - On `unit_ready` = 1, capture `unit_result` into `result`.
  - Next state is DONE, or DRAIN if `flush` = 1 with `unit_ready` = 0.
  - `flush` and `unit_ready` in the same cycle: discard the result and go to IDLE.
- **DRAIN**
  - No done pulse.
  - On `unit_ready` = 1, go to IDLE with the result discarded.
- **DONE**
  - The granted lane's `reqN_done` = 1.
  - Next state is IDLE.
- `unit_ready` is ignored in IDLE, ISSUE and DONE.
- Lane inputs are ignored outside IDLE; the latched operands are used.
- Flush in DONE does not retract the done pulse, which is already registered.
- **Reset mid-operation:** all state returns to IDLE, `last` = 1, and all outputs go to 0. The unit shares the same reset.

## Timing
- Reset values: `req0_done`, `req1_done`, `busy`, `unit_enable` = 0; `result`, `unit_op`, `unit_rdata1`, `unit_rdata2` = 0.
- Request eligible in IDLE at cycle 0:
  - `unit_enable` at cycle 1.
  - `unit_ready` at cycle 1+L, where L is the unit latency.
  - `reqN_done` and `result` at cycle 2+L.
- Requester drops `valid` in the cycle after `done`. IDLE follows DONE, so that lane cannot be granted twice for one request.
- Back-to-back throughput: one operation every L+3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A lane that keeps `valid` asserted while losing arbitration keeps its request. Round-robin bounds its wait to one operation.

## Test plan
- Lane 0 clmul, `rdata1` = 0x00000003, `rdata2` = 0x00000003 -> `req0_done` pulse once, `result` = 0x00000005, `req1_done` stays 0, done at cycle 2+L.
- Lane 1 clmulh, `rdata1` = `rdata2` = 0x80000000 -> `req1_done`, `result` = 0x40000000. Then clmulr with the same operands -> `result` = 0x80000000.
- Both lanes request in the same cycle after reset:
  - Lane 0 served first, then lane 1.
  - A second simultaneous tie grants lane 0 again, because `last` = 1 after serving lane 1.
  - Exactly one `unit_enable` pulse per grant.
- `flush` during WAIT for lane 0 -> no `req0_done`, `busy` stays high until `unit_ready`, then IDLE. A held lane 1 request is granted on the next IDLE cycle.
- `reset` asserted in WAIT -> all outputs 0 immediately (asynchronous). After release, a lane 0 clmul 0x3×0x3 completes normally with `result` = 0x5.
- `op` = 0 with `valid` = 1 -> never granted, `busy` stays 0. `op` = 3'b110 -> executed as clmulh.

Source files
------------

// File: rtl/bit_clmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bit_clmul_arbiter
//  Purpose  : Shares one multi-cycle carry-less multiply unit between two
//             issue lanes. Round-robin arbitration on ties, operand latching,
//             flush handling (unit runs to completion, result dropped) and
//             registered result return to the winning lane.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_clmul_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,        // asynchronous, active-low

   input  logic            req0_valid,
   input  logic [2:0]      req0_op,
   input  logic [XLEN-1:0] req0_rdata1,
   input  logic [XLEN-1:0] req0_rdata2,

   input  logic            req1_valid,
   input  logic [2:0]      req1_op,
   input  logic [XLEN-1:0] req1_rdata1,
   input  logic [XLEN-1:0] req1_rdata2,

   input  logic            flush,

   output logic            req0_done,
   output logic            req1_done,
   output logic [XLEN-1:0] result,
   output logic            busy,

   output logic            unit_enable,
   output logic [2:0]      unit_op,
   output logic [XLEN-1:0] unit_rdata1,
   output logic [XLEN-1:0] unit_rdata2,
   input  logic [XLEN-1:0] unit_result,
   input  logic            unit_ready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Reduce a possibly multi-hot op to one-hot with clmul > clmulh > clmulr.
   function automatic logic [2:0] norm_op(input logic [2:0] op);
      logic [2:0] n;
      n = 3'b000;
      if (op[0])      n = 3'b001;
      else if (op[1]) n = 3'b010;
      else if (op[2]) n = 3'b100;
      return n;
   endfunction

   state_t            state_q, state_d;
   logic              last_q, last_d;        // lane granted most recently
   logic              grant_q, grant_d;      // lane owning the current op
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   rdata1_q, rdata1_d;
   logic [XLEN-1:0]   rdata2_q, rdata2_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic              enable_q, enable_d;
   logic              busy_q, busy_d;

   logic              elig0;
   logic              elig1;
   logic              pick1;                 // 1 when lane 1 wins this cycle

   // Lane eligibility and round-robin winner selection.
   always_comb begin
      elig0 = req0_valid && (req0_op != 3'b000);
      elig1 = req1_valid && (req1_op != 3'b000);
      // Lane 1 wins when it is the only candidate, or on a tie when lane 0
      // was served last.
      pick1 = elig1 && (!elig0 || !last_q);
   end

   // Next-state, operand latching and registered output decode.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      op_d     = op_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (!flush && (elig0 || elig1)) begin
               state_d = S_ISSUE;
               grant_d = pick1;
               last_d  = pick1;
               if (pick1) begin
                  op_d     = norm_op(req1_op);
                  rdata1_d = req1_rdata1;
                  rdata2_d = req1_rdata2;
               end else begin
                  op_d     = norm_op(req0_op);
                  rdata1_d = req0_rdata1;
                  rdata2_d = req0_rdata2;
               end
            end
         end

         S_ISSUE: begin
            state_d = flush ? S_DRAIN : S_WAIT;
         end

         S_WAIT: begin
            if (unit_ready) begin
               // A flush coinciding with completion drops the result.
               if (flush) begin
                  state_d = S_IDLE;
               end else begin
                  result_d = unit_result;
                  state_d  = S_DONE;
               end
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end

         S_DRAIN: begin
            // The unit cannot be aborted; wait for it, then discard.
            if (unit_ready) begin
               state_d = S_IDLE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they leave flops.
      enable_d = (state_d == S_ISSUE);
      busy_d   = (state_d != S_IDLE);
      done0_d  = (state_d == S_DONE) && !grant_d;
      done1_d  = (state_d == S_DONE) &&  grant_d;
   end

   // State and output registers; reset returns everything to idle/zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         last_q   <= 1'b1;
         grant_q  <= 1'b0;
         op_q     <= 3'b000;
         rdata1_q <= '0;
         rdata2_q <= '0;
         result_q <= '0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         op_q     <= op_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
         result_q <= result_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
      end
   end

   assign req0_done   = done0_q;
   assign req1_done   = done1_q;
   assign result      = result_q;
   assign busy        = busy_q;
   assign unit_enable = enable_q;
   assign unit_op     = op_q;
   assign unit_rdata1 = rdata1_q;
   assign unit_rdata2 = rdata2_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_clmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_clmul_arbiter
//  Purpose  : Self-checking bench for bit_clmul_arbiter with a behavioural
//             multi-cycle clmul unit and a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_clmul_arbiter;

   localparam int XLEN = 32;
   localparam int LAT  = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            req0_valid = 1'b0;
   logic [2:0]      req0_op = 3'b000;
   logic [XLEN-1:0] req0_rdata1 = '0, req0_rdata2 = '0;
   logic            req1_valid = 1'b0;
   logic [2:0]      req1_op = 3'b000;
   logic [XLEN-1:0] req1_rdata1 = '0, req1_rdata2 = '0;
   logic            flush = 1'b0;
   logic            req0_done, req1_done, busy, unit_enable;
   logic [XLEN-1:0] result, unit_rdata1, unit_rdata2;
   logic [2:0]      unit_op;
   logic [XLEN-1:0] unit_result = '0;
   logic            unit_ready = 1'b0;

   bit_clmul_arbiter #(.XLEN(XLEN)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op),
      .req0_rdata1(req0_rdata1), .req0_rdata2(req0_rdata2),
      .req1_valid(req1_valid), .req1_op(req1_op),
      .req1_rdata1(req1_rdata1), .req1_rdata2(req1_rdata2),
      .flush(flush),
      .req0_done(req0_done), .req1_done(req1_done),
      .result(result), .busy(busy),
      .unit_enable(unit_enable), .unit_op(unit_op),
      .unit_rdata1(unit_rdata1), .unit_rdata2(unit_rdata2),
      .unit_result(unit_result), .unit_ready(unit_ready)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_en    = 0;
   int n_exp_en = 0;
   logic       en_prev = 1'b0;
   logic [2:0] last_en_op = 3'b000;

   typedef struct {
      int          lane;
      logic [31:0] res;
   } exp_t;
   exp_t sb[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference carry-less multiply for the behavioural unit.
   function automatic logic [31:0] ref_clmul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < 32; i++)
         if (b[i]) p = p ^ ({32'd0, a} << i);
      case (op)
         3'b001:  return p[31:0];
         3'b010:  return p[63:32];
         3'b100:  return p[62:31];
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clock) cyc++;

   // Behavioural unit: result strobe LAT cycles after the start pulse.
   int          u_cnt = 0;
   logic [2:0]  u_op;
   logic [31:0] u_a, u_b;
   always @(posedge clock) begin
      #1;
      if (!reset) begin
         u_cnt      = 0;
         unit_ready = 1'b0;
      end else begin
         unit_ready = 1'b0;
         if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
               unit_ready  = 1'b1;
               unit_result = ref_clmul(u_op, u_a, u_b);
            end
         end
         if (unit_enable) begin
            u_cnt = LAT;
            u_op  = unit_op;
            u_a   = unit_rdata1;
            u_b   = unit_rdata2;
         end
      end
   end

   // Scoreboard pop on every done pulse, plus start-pulse width checks.
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (req0_done || req1_done) begin
            if (req0_done && req1_done) check_val("done_both", 1, 0);
            if (sb.size() == 0) begin
               check_val("unexpected_done", {62'd0, req1_done, req0_done}, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_val("done_lane", req1_done ? 1 : 0, e.lane);
               check_val("result", result, e.res);
            end
         end
         if (en_prev) check_val("enable_pulse", unit_enable, 0);
         en_prev = unit_enable;
         if (unit_enable) begin
            n_en++;
            last_en_op = unit_op;
         end
      end else begin
         en_prev = 1'b0;
      end
   end

   task automatic drive_lane(input int lane, input logic v, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
      if (lane == 0) begin
         req0_valid = v; req0_op = op; req0_rdata1 = a; req0_rdata2 = b;
      end else begin
         req1_valid = v; req1_op = op; req1_rdata1 = a; req1_rdata2 = b;
      end
   endtask

   task automatic run_req(input int lane, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input bit chk_lat);
      int start;
      bit seen;
      @(negedge clock);
      sb.push_back('{lane, exp_res});
      drive_lane(lane, 1'b1, op, a, b);
      n_exp_en++;
      start = cyc;
      seen  = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clock);
         seen = (lane == 0) ? req0_done : req1_done;
      end
      if (!seen) check_val("done_timeout", 0, 1);
      else if (chk_lat) check_val("done_latency", cyc - start, 2 + LAT);
      drive_lane(lane, 1'b0, 3'b000, 32'd0, 32'd0);
   endtask

   task automatic run_tie(input logic [31:0] e0, input logic [31:0] a1,
                          input logic [31:0] b1, input logic [31:0] e1);
      bit got0, got1;
      @(negedge clock);
      sb.push_back('{0, e0});
      sb.push_back('{1, e1});
      drive_lane(0, 1'b1, 3'b001, 32'h3, 32'h3);
      drive_lane(1, 1'b1, 3'b001, a1, b1);
      n_exp_en += 2;
      got0 = 1'b0;
      got1 = 1'b0;
      for (int k = 0; k < 200 && !(got0 && got1); k++) begin
         @(negedge clock);
         if (req0_done) begin got0 = 1'b1; drive_lane(0, 1'b0, 3'b000, 32'd0, 32'd0); end
         if (req1_done) begin got1 = 1'b1; drive_lane(1, 1'b0, 3'b000, 32'd0, 32'd0); end
      end
      if (!(got0 && got1)) check_val("tie_timeout", 0, 1);
   endtask

   task automatic wait_enable(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clock);
         ok = unit_enable;
      end
      if (!ok) check_val("enable_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      sb.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      bit ok;
      int rcyc;
      bit rdy;

      // Reset state
      repeat (3) @(negedge clock);
      check_val("rst_busy", busy, 0);
      check_val("rst_enable", unit_enable, 0);
      check_val("rst_done", {req1_done, req0_done}, 0);
      check_val("rst_result", result, 0);
      check_val("rst_unit_op", unit_op, 0);
      check_val("rst_rdata", {unit_rdata1, unit_rdata2}, 0);
      reset = 1'b1;

      // Single-lane operations
      run_req(0, 3'b001, 32'h3, 32'h3, 32'h5, 1'b1);
      run_req(1, 3'b010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
      run_req(1, 3'b100, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);

      // Ties after reset: lane 0, lane 1, then lane 0 again
      do_reset();
      run_tie(32'h5, 32'h7, 32'h3, 32'h9);
      run_tie(32'h5, 32'hF, 32'h3, 32'h11);

      // Flush during WAIT with lane 1 held
      @(negedge clock);
      drive_lane(0, 1'b1, 3'b001, 32'h1234, 32'h5);
      n_exp_en++;
      wait_enable(ok);
      sb.push_back('{1, 32'h0000_00FF});
      drive_lane(1, 1'b1, 3'b001, 32'h55, 32'h3);
      n_exp_en++;
      @(negedge clock);
      check_val("wait_busy", busy, 1);
      flush = 1'b1;
      drive_lane(0, 1'b0, 3'b000, 32'd0, 32'd0);
      @(negedge clock);
      flush = 1'b0;
      rdy = 1'b0;
      rcyc = 0;
      for (int k = 0; k < 50 && !rdy; k++) begin
         check_val("drain_busy", busy, 1);
         rdy = unit_ready;
         rcyc = cyc;
         if (!rdy) @(negedge clock);
      end
      if (!rdy) check_val("drain_timeout", 0, 1);
      wait_enable(ok);
      if (ok) check_val("regrant_delay", cyc - rcyc, 2);
      rdy = 1'b0;
      for (int k = 0; k < 50 && !rdy; k++) begin
         @(negedge clock);
         rdy = req1_done;
      end
      if (!rdy) check_val("lane1_timeout", 0, 1);
      drive_lane(1, 1'b0, 3'b000, 32'd0, 32'd0);

      // Asynchronous reset while in WAIT
      @(negedge clock);
      drive_lane(0, 1'b1, 3'b001, 32'h3, 32'h3);
      n_exp_en++;
      wait_enable(ok);
      @(negedge clock);
      check_val("pre_rst_busy", busy, 1);
      reset = 1'b0;
      #1;
      check_val("arst_busy", busy, 0);
      check_val("arst_done", {req1_done, req0_done}, 0);
      check_val("arst_result", result, 0);
      check_val("arst_unit", {unit_enable, unit_op}, 0);
      check_val("arst_rdata", {unit_rdata1, unit_rdata2}, 0);
      drive_lane(0, 1'b0, 3'b000, 32'd0, 32'd0);
      sb.delete();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      run_req(0, 3'b001, 32'h3, 32'h3, 32'h5, 1'b1);

      // op = 0 is never granted
      @(negedge clock);
      drive_lane(0, 1'b1, 3'b000, 32'h3, 32'h3);
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check_val("op0_busy", {unit_enable, busy}, 0);
      end
      drive_lane(0, 1'b0, 3'b000, 32'd0, 32'd0);

      // Multi-hot op 110 runs as clmulh
      run_req(1, 3'b110, 32'h8000_0001, 32'h8000_0003, 32'h4000_0001, 1'b0);
      check_val("norm_op", last_en_op, 3'b010);

      // A few random one-hot operations
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, b;
         logic [2:0]  op;
         int ln;
         a  = $urandom;
         b  = $urandom;
         op = 3'b001 << $urandom_range(0, 2);
         ln = $urandom_range(0, 1);
         run_req(ln, op, a, b, ref_clmul(op, a, b), 1'b1);
      end

      repeat (3) @(negedge clock);
      check_val("enable_count", n_en, n_exp_en);
      check_val("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
